// File: rtl/axi4_burst_mem_responder.sv
// ---------------------------------------------------------------------------
// axi4_burst_mem_responder
//
// Single-port AXI4 slave memory. It serves cache line refills (reads) and
// dirty-line write-backs (writes) from the core's cache FSMs. Only INCR
// bursts are supported, with one outstanding transaction at a time. The
// read latency is programmable.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   s_ar*                 read address channel  (araddr byte address, arlen = beats-1)
//   s_r*                  read data channel     (rresp OKAY=00 / SLVERR=10, rlast)
//   s_aw*                 write address channel (awaddr byte address, awlen = beats-1)
//   s_w*                  write data channel    (wstrb byte enables, wlast)
//   s_b*                  write response channel (bresp OKAY=00 / SLVERR=10)
//
// Parameters:
//   ADDR_W     byte address width
//   DATA_W     data bus width (4-byte words)
//   MEM_WORDS  depth of the word array (power of two)
//   READ_LAT   idle cycles between the AR handshake and the first R beat (0..15)
// ---------------------------------------------------------------------------
module axi4_burst_mem_responder #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 4096,
  parameter int READ_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wlast,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp
);

  localparam int IW    = ADDR_W - 2;
  localparam int IDX_W = $clog2(MEM_WORDS);
  // Last value of the latency counter before the first beat is loaded.
  localparam logic [3:0] LAT_LAST = (READ_LAT == 0) ? 4'd0 : 4'(READ_LAT - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_BEAT = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [DATA_W-1:0] mem_r [MEM_WORDS];

  logic [IW-1:0]     start_r;
  logic [7:0]        len_r;
  logic [7:0]        beat_r;
  logic [3:0]        lat_r;
  logic              prio_r;     // 0 = read wins a tie, 1 = write wins a tie
  logic              werr_r;     // sticky write error for the current burst
  logic [1:0]        bresp_r;
  logic [DATA_W-1:0] rdata_r;
  logic [1:0]        rresp_r;
  logic              rlast_r;

  logic              ar_win_s;
  logic              aw_win_s;
  logic              rd_load_en_s;
  logic [IW-1:0]     rd_load_idx_s;
  logic              rd_load_last_s;
  logic [IW-1:0]     wr_idx_s;
  logic              wr_last_s;
  logic              wr_beat_err_s;
  logic              unused_s;

  // True when a word index maps onto the array.
  function automatic logic in_range(input logic [IW-1:0] idx);
    return (idx < IW'(MEM_WORDS));
  endfunction

  // Byte-lane bits [1:0] of the addresses are ignored.
  assign unused_s = ^{s_araddr[1:0], s_awaddr[1:0]};

  // Arbitration between AR and AW while idle; a tie goes to the priority flag.
  always_comb begin
    ar_win_s = 1'b0;
    aw_win_s = 1'b0;
    if (!rst && state_r == ST_IDLE) begin
      if (s_arvalid && s_awvalid) begin
        ar_win_s = ~prio_r;
        aw_win_s = prio_r;
      end else begin
        ar_win_s = s_arvalid;
        aw_win_s = s_awvalid;
      end
    end else begin
      ar_win_s = 1'b0;
      aw_win_s = 1'b0;
    end
  end

  // Write beat address and per-beat error detection.
  always_comb begin
    wr_idx_s      = start_r + IW'(beat_r);
    wr_last_s     = (beat_r == len_r);
    wr_beat_err_s = !in_range(wr_idx_s) || (s_wlast != wr_last_s);
  end

  // Selects when and from where the read data register is loaded.
  always_comb begin
    rd_load_en_s   = 1'b0;
    rd_load_idx_s  = '0;
    rd_load_last_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // With zero latency the handshake cycle itself performs the array read.
        if (ar_win_s && READ_LAT == 0) begin
          rd_load_en_s   = 1'b1;
          rd_load_idx_s  = s_araddr[ADDR_W-1:2];
          rd_load_last_s = (s_arlen == 8'd0);
        end else begin
          rd_load_en_s   = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        if (lat_r == LAT_LAST) begin
          rd_load_en_s   = 1'b1;
          rd_load_idx_s  = start_r;
          rd_load_last_s = (len_r == 8'd0);
        end else begin
          rd_load_en_s   = 1'b0;
        end
      end
      ST_RD_BEAT: begin
        // Prefetch the next beat on a non-final handshake for 1 beat/cycle.
        if (s_rready && !rlast_r) begin
          rd_load_en_s   = 1'b1;
          rd_load_idx_s  = start_r + IW'(beat_r) + IW'(1);
          rd_load_last_s = ((beat_r + 8'd1) == len_r);
        end else begin
          rd_load_en_s   = 1'b0;
        end
      end
      default: begin
        rd_load_en_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ar_win_s) begin
          state_next_s = (READ_LAT == 0) ? ST_RD_BEAT : ST_RD_WAIT;
        end else if (aw_win_s) begin
          state_next_s = ST_WR_DATA;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (lat_r == LAT_LAST) begin
          state_next_s = ST_RD_BEAT;
        end else begin
          state_next_s = ST_RD_WAIT;
        end
      end
      ST_RD_BEAT: begin
        if (s_rready && rlast_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RD_BEAT;
        end
      end
      ST_WR_DATA: begin
        if (s_wvalid && wr_last_s) begin
          state_next_s = ST_WR_RESP;
        end else begin
          state_next_s = ST_WR_DATA;
        end
      end
      ST_WR_RESP: begin
        if (s_bready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WR_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: handshake signals decoded from state and arbitration.
  always_comb begin
    s_arready = ar_win_s;
    s_awready = aw_win_s;
    s_rvalid  = (state_r == ST_RD_BEAT);
    s_wready  = (state_r == ST_WR_DATA);
    s_bvalid  = (state_r == ST_WR_RESP);
    s_rdata   = rdata_r;
    s_rresp   = rresp_r;
    s_rlast   = rlast_r;
    s_bresp   = bresp_r;
  end

  // Burst bookkeeping: captured address/length, counters, priority, write error.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_r <= '0;
      len_r   <= 8'd0;
      beat_r  <= 8'd0;
      lat_r   <= 4'd0;
      prio_r  <= 1'b0;
      werr_r  <= 1'b0;
      bresp_r <= RESP_OKAY;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ar_win_s) begin
            start_r <= s_araddr[ADDR_W-1:2];
            len_r   <= s_arlen;
            beat_r  <= 8'd0;
            lat_r   <= 4'd0;
          end else if (aw_win_s) begin
            start_r <= s_awaddr[ADDR_W-1:2];
            len_r   <= s_awlen;
            beat_r  <= 8'd0;
            werr_r  <= 1'b0;
          end
          if (s_arvalid && s_awvalid) begin
            prio_r <= ~prio_r;
          end
        end
        ST_RD_WAIT: begin
          lat_r <= lat_r + 4'd1;
        end
        ST_RD_BEAT: begin
          if (s_rready && !rlast_r) begin
            beat_r <= beat_r + 8'd1;
          end
        end
        ST_WR_DATA: begin
          if (s_wvalid) begin
            if (wr_beat_err_s) begin
              werr_r <= 1'b1;
            end
            if (wr_last_s) begin
              bresp_r <= (werr_r || wr_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              beat_r <= beat_r + 8'd1;
            end
          end
        end
        ST_WR_RESP: begin
          if (s_bready) begin
            werr_r  <= 1'b0;
            bresp_r <= RESP_OKAY;
          end
        end
        default: begin
          beat_r <= 8'd0;
        end
      endcase
    end
  end

  // Registered read beat: data, response and last flag, held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
      rresp_r <= RESP_OKAY;
      rlast_r <= 1'b0;
    end else if (rd_load_en_s) begin
      if (in_range(rd_load_idx_s)) begin
        rdata_r <= mem_r[rd_load_idx_s[IDX_W-1:0]];
        rresp_r <= RESP_OKAY;
      end else begin
        rdata_r <= '0;
        rresp_r <= RESP_SLVERR;
      end
      rlast_r <= rd_load_last_s;
    end else if (state_r == ST_RD_BEAT && s_rready && rlast_r) begin
      rlast_r <= 1'b0;
    end
  end

  // Byte-masked array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && state_r == ST_WR_DATA && s_wvalid && in_range(wr_idx_s)) begin
      for (int b = 0; b < 4; b++) begin
        if (s_wstrb[b]) begin
          mem_r[wr_idx_s[IDX_W-1:0]][8*b +: 8] <= s_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
